// File: rtl/jtag_tap_master.sv
// JTAG TAP master: turns TLR / IR-shift / DR-shift / run-idle commands into TCK/TMS/TDI
// sequences and returns captured TDO. Define JTAG_TAP_MASTER_CHECK_EN to add the TDO compare.
module jtag_tap_master #(
    parameter int DATA_W  = 64,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_type_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              jtag_tck_o,
    output logic              jtag_tms_o,
    output logic              jtag_tdi_o,
    input  logic              jtag_tdo_i
`ifdef JTAG_TAP_MASTER_CHECK_EN
    ,
    input  logic [DATA_W-1:0] cmd_exp_i,
    input  logic [DATA_W-1:0] cmd_mask_i,
    output logic              rsp_err_o
`endif
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never waits for ready, and payload is held stable while valid is high and ready is low.

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] T_TLR  = 2'b00;
    localparam logic [1:0] T_IR   = 2'b01;
    localparam logic [1:0] T_DR   = 2'b10;
    localparam logic [1:0] T_RUNI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SEL, S_SHIFT, S_EXIT, S_RUNI, S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]  div_q;
    logic              tck_q, tms_q, tdi_q;
    logic [CNT_W-1:0]  tick_q, tick_d, n_ticks;
    logic [LEN_W-1:0]  len_q, cmd_len_c;
    logic [1:0]        type_q, type_c;
    logic [DATA_W-1:0] tx_q, cap_q, cap_shift, res_data;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              active, half_end, rise, fall, last_tick, is_shift;
    logic              accept, load, tms_d, tdi_d;

    assign active   = (state_q != S_IDLE) && (state_q != S_RESP);
    assign half_end = active && (div_q == DIV_LAST);
    assign rise     = half_end && !tck_q;
    assign fall     = half_end && tck_q;
    assign is_shift = (type_q == T_IR) || (type_q == T_DR);

    // The command type is only latched at accept, so SEL's first tick reads it from the port
    assign type_c    = (state_q == S_IDLE) ? cmd_type_i : type_q;
    assign cmd_len_c = (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;

    always_comb begin
        n_ticks = CNT_W'(1);
        case (state_q)
            S_RST:   n_ticks = CNT_W'(6);
            S_SEL:   n_ticks = (type_q == T_IR) ? CNT_W'(4) : CNT_W'(3);
            S_SHIFT: n_ticks = CNT_W'(len_q);
            S_EXIT:  n_ticks = CNT_W'(2);
            S_RUNI:  n_ticks = CNT_W'(len_q);
            default: n_ticks = CNT_W'(1);
        endcase
    end

    assign last_tick = (tick_q == n_ticks - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        accept  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    accept = 1'b1;
                    tick_d = '0;
                    case (cmd_type_i)
                        T_TLR: begin
                            state_d = S_RST;
                            load    = 1'b1;
                        end
                        T_RUNI: begin
                            state_d = (cmd_len_c == '0) ? S_RESP : S_RUNI;
                            load    = (cmd_len_c != '0);
                        end
                        default: begin
                            state_d = (cmd_len_c == '0) ? S_RESP : S_SEL;
                            load    = (cmd_len_c != '0);
                        end
                    endcase
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready_i) state_d = S_IDLE;
            end
            default: begin
                // Each tick ends on the TCK falling edge, where the next TMS/TDI is launched
                if (fall) begin
                    if (!last_tick) begin
                        tick_d = tick_q + CNT_W'(1);
                        load   = 1'b1;
                    end else begin
                        tick_d = '0;
                        case (state_q)
                            S_SEL: begin
                                state_d = S_SHIFT;
                                load    = 1'b1;
                            end
                            S_SHIFT: begin
                                state_d = S_EXIT;
                                load    = 1'b1;
                            end
                            default: state_d = S_RESP;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        tms_d = tms_q;
        tdi_d = 1'b0;
        case (state_d)
            S_RST:   tms_d = (tick_d != CNT_W'(5));
            S_SEL:   tms_d = (type_c == T_IR) ? (tick_d < CNT_W'(2)) : (tick_d == '0);
            S_SHIFT: begin
                tms_d = (tick_d == CNT_W'(len_q) - CNT_W'(1));
                tdi_d = tx_q[0];
            end
            S_EXIT:  tms_d = (tick_d == '0);
            S_RUNI:  tms_d = 1'b0;
            default: tms_d = tms_q;
        endcase
    end

    // Capture fills from the MSB; the final right shift by (DATA_W-len) right-aligns it
    always_comb begin
        cap_shift = cap_q >> 1;
        cap_shift[DATA_W-1] = jtag_tdo_i;
        res_data = is_shift ? (cap_q >> (MAX_LEN - len_q)) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            tick_q      <= '0;
            len_q       <= '0;
            type_q      <= T_TLR;
            tx_q        <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            tick_q <= tick_d;
            if (half_end) begin
                div_q <= '0;
                tck_q <= ~tck_q;
            end else if (active) begin
                div_q <= div_q + 1'b1;
            end
            if (load) begin
                tms_q <= tms_d;
                tdi_q <= tdi_d;
            end
            if (load && (state_d == S_SHIFT)) tx_q <= tx_q >> 1;
            if (accept) begin
                len_q  <= cmd_len_c;
                type_q <= cmd_type_i;
                tx_q   <= cmd_data_i;
                cap_q  <= '0;
            end
            if (rise && (state_q == S_SHIFT)) cap_q <= cap_shift;
            if ((state_q == S_RESP) && !rsp_valid_q) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= res_data;
            end else if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef JTAG_TAP_MASTER_CHECK_EN
    logic [DATA_W-1:0] exp_q, mask_q, len_mask;
    logic              err_q;

    assign len_mask = {DATA_W{1'b1}} >> (MAX_LEN - len_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_q  <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                exp_q  <= cmd_exp_i;
                mask_q <= cmd_mask_i;
            end
            if ((state_q == S_RESP) && !rsp_valid_q)
                err_q <= is_shift && (|((res_data ^ exp_q) & mask_q & len_mask));
        end
    end

    assign rsp_err_o = err_q;
`endif

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign jtag_tck_o  = tck_q;
    assign jtag_tms_o  = tms_q;
    assign jtag_tdi_o  = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master with a behavioural TAP slave (IDCODE / BYPASS).
module tb_jtag_tap_master;

    localparam int DATA_W  = 64;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = $clog2(DATA_W + 1);
    localparam logic [31:0] IDCODE = 32'h1000_5A5B;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_type = 2'b00;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              jtag_tck, jtag_tms, jtag_tdi;
    logic              jtag_tdo = 1'b0;
`ifdef JTAG_TAP_MASTER_CHECK_EN
    logic [DATA_W-1:0] cmd_exp = '0;
    logic [DATA_W-1:0] cmd_mask = '0;
    logic              rsp_err;
`endif

    jtag_tap_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_type_i  (cmd_type),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy),
        .jtag_tck_o  (jtag_tck),
        .jtag_tms_o  (jtag_tms),
        .jtag_tdi_o  (jtag_tdi),
        .jtag_tdo_i  (jtag_tdo)
`ifdef JTAG_TAP_MASTER_CHECK_EN
        ,
        .cmd_exp_i   (cmd_exp),
        .cmd_mask_i  (cmd_mask),
        .rsp_err_o   (rsp_err)
`endif
    );

    // TAP slave model: state moves and shifts on rising TCK, TDO changes on falling TCK
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t        tap = TLR;
    logic [4:0]  ir = 5'h01;
    logic [4:0]  ir_sr = 5'h00;
    logic [31:0] dr_sr = 32'h0;
    int          tck_rises = 0;
    logic [63:0] tms_hist = '0;

    always @(posedge jtag_tck) begin
        tck_rises++;
        tms_hist = {tms_hist[62:0], jtag_tms};
        case (tap)
            TLR:    ir = 5'h01;
            CAP_DR: dr_sr = (ir == 5'h01) ? IDCODE : 32'h0;
            SH_DR:  dr_sr = (ir == 5'h01) ? {jtag_tdi, dr_sr[31:1]} : {31'h0, jtag_tdi};
            CAP_IR: ir_sr = 5'b00001;
            SH_IR:  ir_sr = {jtag_tdi, ir_sr[4:1]};
            UPD_IR: ir = ir_sr;
            default: ;
        endcase
        case (tap)
            TLR:    tap = jtag_tms ? TLR    : RTI;
            RTI:    tap = jtag_tms ? SEL_DR : RTI;
            SEL_DR: tap = jtag_tms ? SEL_IR : CAP_DR;
            CAP_DR: tap = jtag_tms ? EX1_DR : SH_DR;
            SH_DR:  tap = jtag_tms ? EX1_DR : SH_DR;
            EX1_DR: tap = jtag_tms ? UPD_DR : PAU_DR;
            PAU_DR: tap = jtag_tms ? EX2_DR : PAU_DR;
            EX2_DR: tap = jtag_tms ? UPD_DR : SH_DR;
            UPD_DR: tap = jtag_tms ? SEL_DR : RTI;
            SEL_IR: tap = jtag_tms ? TLR    : CAP_IR;
            CAP_IR: tap = jtag_tms ? EX1_IR : SH_IR;
            SH_IR:  tap = jtag_tms ? EX1_IR : SH_IR;
            EX1_IR: tap = jtag_tms ? UPD_IR : PAU_IR;
            PAU_IR: tap = jtag_tms ? EX2_IR : PAU_IR;
            EX2_IR: tap = jtag_tms ? UPD_IR : SH_IR;
            default: tap = jtag_tms ? SEL_DR : RTI;
        endcase
    end

    always @(negedge jtag_tck) begin
        jtag_tdo = (tap == SH_DR) ? dr_sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [DATA_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int acc_cyc = 0;
    int base_rises = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic send_cmd(input logic [1:0] t, input int l, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_type   = t;
        cmd_len    = LEN_W'(l);
        cmd_data   = d;
        base_rises = tck_rises;
        @(negedge clk);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom_range(0, 3));
        cmd_data  = {$urandom, $urandom};
        check("busy_after_accept", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
    endtask

    task automatic take_rsp(input string tag, input int exp_ticks);
        logic [DATA_W-1:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_ticks"}, 64'(tck_rises - base_rises), 64'(exp_ticks));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_idle"}, {cmd_ready, busy, rsp_valid, jtag_tck}, 4'b1000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_ready_busy_valid", {cmd_ready, busy, rsp_valid}, 3'b100);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_pins", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);
`ifdef JTAG_TAP_MASTER_CHECK_EN
        check("rst_rsp_err", rsp_err, 1'b0);
`endif
        rst = 1'b0;

        // TAP reset: 6 ticks, TMS 111110, response 25 cycles after accept
        exp_q.push_back('0);
        send_cmd(2'b00, 0, 64'hDEAD);
        wait_valid("tlr", 25);
        check("tlr_tms_seq", tms_hist[5:0], 6'b111110);
        check("tlr_tap_state", tap, RTI);
        take_rsp("tlr", 6);

        // IR capture reads back 5'b00001; then IDCODE read
        exp_q.push_back(64'h01);
        send_cmd(2'b01, 5, 64'h01);
        wait_valid("ir_idcode", 45);
        take_rsp("ir_idcode", 11);
        check("ir_idcode_loaded", {ir, tap}, {5'h01, RTI});

        exp_q.push_back({32'h0, IDCODE});
        send_cmd(2'b10, 32, 64'h0);
        wait_valid("dr_idcode", 149);
        take_rsp("dr_idcode", 37);

        // BYPASS: captured 0 then TDI delayed one bit
        exp_q.push_back(64'h01);
        send_cmd(2'b01, 5, 64'h1F);
        wait_valid("ir_bypass", 45);
        take_rsp("ir_bypass", 11);
        check("ir_bypass_loaded", ir, 5'h1F);

        // response held while rsp_ready stays low
        exp_q.push_back(64'h4A);
        send_cmd(2'b10, 8, 64'hA5);
        wait_valid("dr_bypass", 53);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_flags", {rsp_valid, cmd_ready, busy, jtag_tck}, 4'b1010);
            check("hold_data", rsp_data, 64'h4A);
        end
        take_rsp("dr_bypass", 13);

        // zero-length shift: no TCK, response next cycle
        exp_q.push_back('0);
        send_cmd(2'b10, 0, 64'hFFFF);
        wait_valid("dr_len0", 1);
        take_rsp("dr_len0", 0);

        // over-long length clamps to DATA_W
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        send_cmd(2'b10, 100, {64{1'b1}});
        wait_valid("dr_clamp", 277);
        take_rsp("dr_clamp", 69);

        // run-idle
        exp_q.push_back('0);
        send_cmd(2'b11, 3, 64'hFF);
        wait_valid("runi3", 13);
        check("runi3_tms", {tms_hist[2:0], tap}, {3'b000, RTI});
        take_rsp("runi3", 3);

        exp_q.push_back('0);
        send_cmd(2'b11, 0, 64'hFF);
        wait_valid("runi0", 1);
        take_rsp("runi0", 0);

        // reset during shift bit 3 of a 16-bit DR shift (3 SEL ticks precede it)
        send_cmd(2'b10, 16, 64'h1234);
        n = 0;
        while ((tck_rises - base_rises) < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reached", 64'(tck_rises - base_rises), 64'd7);
        check("mid_rst_tck_high", jtag_tck, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pins", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);
        check("mid_rst_flags", {busy, cmd_ready, rsp_valid}, 3'b010);
        rst = 1'b0;

        exp_q.push_back('0);
        send_cmd(2'b00, 0, 64'h0);
        wait_valid("tlr2", 25);
        check("tlr2_tap_state", tap, RTI);
        take_rsp("tlr2", 6);

`ifdef JTAG_TAP_MASTER_CHECK_EN
        cmd_exp  = 64'h1000_5A5A;
        cmd_mask = 64'h1;
        exp_q.push_back({32'h0, IDCODE});
        send_cmd(2'b10, 32, 64'h0);
        wait_valid("chk_err", 149);
        check("chk_err_flag", rsp_err, 1'b1);
        take_rsp("chk_err", 37);

        cmd_mask = 64'h0;
        exp_q.push_back({32'h0, IDCODE});
        send_cmd(2'b10, 32, 64'h0);
        wait_valid("chk_ok", 149);
        check("chk_ok_flag", rsp_err, 1'b0);
        take_rsp("chk_ok", 37);
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
